// File: rtl/mem_ctrl_if.sv
// Bundle between the cpu memory channels, the controller and the single-port word memory.
interface mem_ctrl_if #(parameter int W = 32);
  logic         pc_clk;
  logic [W-1:0] pc;
  logic [W-1:0] read_inst;
  logic         load_clk;
  logic         load_en;
  logic [W-1:0] l_addr;
  logic [W-1:0] l_data;
  logic         store_clk;
  logic         store_en;
  logic [W-1:0] s_addr;
  logic [W-1:0] s_data;
  logic         busy;
  logic         err_overrun;
  logic         err_timeout;
  logic         mem_req;
  logic         mem_we;
  logic [W-1:0] mem_addr;
  logic [W-1:0] mem_wdata;
  logic         mem_ack;
  logic [W-1:0] mem_rdata;

  modport slave (
    input  pc_clk, pc, load_clk, load_en, l_addr, store_clk, store_en, s_addr, s_data,
           mem_ack, mem_rdata,
    output read_inst, l_data, busy, err_overrun, err_timeout,
           mem_req, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output pc_clk, pc, load_clk, load_en, l_addr, store_clk, store_en, s_addr, s_data,
           mem_ack, mem_rdata,
    input  read_inst, l_data, busy, err_overrun, err_timeout,
           mem_req, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_ctrl.sv
// Serialises fetch/load/store strobes onto one req/ack word memory, priority store > load > fetch;
// data visible 2 cycles after strobe at best. MEM_CTRL_TIMEOUT_EN bounds the ack wait to TIMEOUT_CYCLES.
module mem_ctrl #(
  parameter int W = 32
`ifdef MEM_CTRL_TIMEOUT_EN
  ,parameter int TIMEOUT_CYCLES = 255
`endif
) (
  input  logic      i_clk,
  input  logic      i_rst,
  mem_ctrl_if.slave io_bus
);

  typedef enum logic {S_IDLE, S_BUSY} state_t;
  typedef enum logic [1:0] {CH_FETCH, CH_LOAD, CH_STORE} chan_t;

  state_t       r_state;
  chan_t        r_chan;
  logic         r_pend_f;
  logic         r_pend_l;
  logic         r_pend_s;
  logic [W-1:0] r_pc;
  logic [W-1:0] r_laddr;
  logic [W-1:0] r_saddr;
  logic [W-1:0] r_sdata;
  logic         r_req;
  logic         r_we;
  logic [W-1:0] r_addr;
  logic [W-1:0] r_wdata;
  logic [W-1:0] r_inst;
  logic [W-1:0] r_ldata;
  logic         r_ovr;

  logic         w_stb_f;
  logic         w_stb_l;
  logic         w_stb_s;
  logic         w_ack;
  logic         w_tmo;
  logic         w_done;
  logic [W-1:0] w_rdata;
  logic [W-1:0] w_word_mask;

  assign w_stb_f     = io_bus.pc_clk;
  assign w_stb_l     = io_bus.load_clk & io_bus.load_en;
  assign w_stb_s     = io_bus.store_clk & io_bus.store_en;
  assign w_ack       = (r_state == S_BUSY) && io_bus.mem_ack;
  assign w_word_mask = ~W'(3);

`ifdef MEM_CTRL_TIMEOUT_EN
  // Counter spans 0..TIMEOUT_CYCLES-1; the edge after the last value gives up.
  localparam int CW = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] r_wait;
  logic          r_tmo;

  assign w_tmo              = (r_state == S_BUSY) && !io_bus.mem_ack && (r_wait == LAST);
  assign w_rdata            = w_ack ? io_bus.mem_rdata : '1;
  assign io_bus.err_timeout = r_tmo;
`else
  assign w_tmo              = 1'b0;
  assign w_rdata            = io_bus.mem_rdata;
  assign io_bus.err_timeout = 1'b0;
`endif

  assign w_done = w_ack | w_tmo;

  // A strobe on a channel that is still pending (queued or in flight) is dropped.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_pend_f <= 1'b0;
      r_pend_l <= 1'b0;
      r_pend_s <= 1'b0;
      r_pc     <= '0;
      r_laddr  <= '0;
      r_saddr  <= '0;
      r_sdata  <= '0;
      r_ovr    <= 1'b0;
    end else begin
      if (w_done && r_chan == CH_FETCH) r_pend_f <= 1'b0;
      if (w_done && r_chan == CH_LOAD)  r_pend_l <= 1'b0;
      if (w_done && r_chan == CH_STORE) r_pend_s <= 1'b0;
      if (w_stb_f && !r_pend_f) begin
        r_pend_f <= 1'b1;
        r_pc     <= io_bus.pc;
      end
      if (w_stb_l && !r_pend_l) begin
        r_pend_l <= 1'b1;
        r_laddr  <= io_bus.l_addr;
      end
      if (w_stb_s && !r_pend_s) begin
        r_pend_s <= 1'b1;
        r_saddr  <= io_bus.s_addr;
        r_sdata  <= io_bus.s_data;
      end
      if ((w_stb_f && r_pend_f) || (w_stb_l && r_pend_l) || (w_stb_s && r_pend_s))
        r_ovr <= 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= S_IDLE;
      r_chan  <= CH_FETCH;
      r_req   <= 1'b0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_inst  <= '0;
      r_ldata <= '0;
`ifdef MEM_CTRL_TIMEOUT_EN
      r_wait  <= '0;
      r_tmo   <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (r_pend_s || r_pend_l || r_pend_f) begin
            r_req   <= 1'b1;
            r_state <= S_BUSY;
`ifdef MEM_CTRL_TIMEOUT_EN
            r_wait  <= '0;
`endif
            if (r_pend_s) begin
              r_chan  <= CH_STORE;
              r_we    <= 1'b1;
              r_addr  <= r_saddr & w_word_mask;
              r_wdata <= r_sdata;
            end else if (r_pend_l) begin
              r_chan  <= CH_LOAD;
              r_we    <= 1'b0;
              r_addr  <= r_laddr & w_word_mask;
            end else begin
              r_chan  <= CH_FETCH;
              r_we    <= 1'b0;
              r_addr  <= r_pc & w_word_mask;
            end
          end
        end
        S_BUSY: begin
          if (w_done) begin
            r_req   <= 1'b0;
            r_state <= S_IDLE;
            if (r_chan == CH_LOAD)  r_ldata <= w_rdata;
            if (r_chan == CH_FETCH) r_inst  <= w_rdata;
`ifdef MEM_CTRL_TIMEOUT_EN
            if (w_tmo) r_tmo <= 1'b1;
`endif
          end
`ifdef MEM_CTRL_TIMEOUT_EN
          else begin
            r_wait <= r_wait + CW'(1);
          end
`endif
        end
      endcase
    end
  end

  assign io_bus.mem_req     = r_req;
  assign io_bus.mem_we      = r_we;
  assign io_bus.mem_addr    = r_addr;
  assign io_bus.mem_wdata   = r_wdata;
  assign io_bus.read_inst   = r_inst;
  assign io_bus.l_data      = r_ldata;
  assign io_bus.err_overrun = r_ovr;
  assign io_bus.busy        = r_pend_f | r_pend_l | r_pend_s | (r_state == S_BUSY);

endmodule

// File: tb/tb_mem_ctrl.sv
// Bench for mem_ctrl: directed scenarios plus randomized transaction sets checked against a reference memory.
`timescale 1ns/1ps
module tb_mem_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mem_ctrl_if #(.W(32)) bus ();

`ifdef MEM_CTRL_TIMEOUT_EN
  mem_ctrl #(.W(32), .TIMEOUT_CYCLES(4)) dut (.i_clk(clk), .i_rst(rst), .io_bus(bus));
`else
  mem_ctrl #(.W(32)) dut (.i_clk(clk), .i_rst(rst), .io_bus(bus));
`endif

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } txn_t;

  int   lat       = 0;
  bit   ack_en    = 1'b1;
  bit   force_ack = 1'b0;
  txn_t log_q[$];
  logic [31:0] mem_arr [logic [31:0]];
  logic [31:0] ref_mem [logic [31:0]];

  function automatic logic [31:0] dflt(input logic [31:0] a);
    return {a[15:0], ~a[15:0]};
  endfunction

  function automatic logic [31:0] ref_rd(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : dflt(a);
  endfunction

  // Memory model: acks a held request after 'lat' extra cycles, logs every accepted access.
  initial begin : responder
    int   wcnt;
    txn_t t;
    wcnt          = 0;
    bus.mem_ack   = 1'b0;
    bus.mem_rdata = '0;
    forever begin
      @(negedge clk);
      if (force_ack) begin
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = 32'hDEAD_BEEF;
      end else if (bus.mem_req && ack_en && !bus.mem_ack) begin
        if (wcnt >= lat) begin
          wcnt        = 0;
          bus.mem_ack = 1'b1;
          t.we    = bus.mem_we;
          t.addr  = bus.mem_addr;
          t.wdata = bus.mem_wdata;
          log_q.push_back(t);
          if (bus.mem_we) begin
            mem_arr[bus.mem_addr] = bus.mem_wdata;
            bus.mem_rdata = 32'hBAD0_BAD0;
          end else begin
            bus.mem_rdata = mem_arr.exists(bus.mem_addr) ? mem_arr[bus.mem_addr] : dflt(bus.mem_addr);
          end
        end else begin
          wcnt++;
          bus.mem_ack = 1'b0;
        end
      end else begin
        bus.mem_ack = 1'b0;
        if (!bus.mem_req) wcnt = 0;
      end
    end
  end

  initial begin : watchdog
    #500us;
    $display("FAIL watchdog: simulation did not finish, got running exp finished");
    $fatal(1, "watchdog");
  end

  task automatic strobe(input bit f, input logic [31:0] pcv, input bit l, input bit len,
                        input logic [31:0] la, input bit s, input bit sen,
                        input logic [31:0] sa, input logic [31:0] sd);
    bus.pc_clk    = f;
    bus.pc        = pcv;
    bus.load_clk  = l;
    bus.load_en   = len;
    bus.l_addr    = la;
    bus.store_clk = s;
    bus.store_en  = sen;
    bus.s_addr    = sa;
    bus.s_data    = sd;
    @(negedge clk);
    bus.pc_clk    = 1'b0;
    bus.load_clk  = 1'b0;
    bus.load_en   = 1'b0;
    bus.store_clk = 1'b0;
    bus.store_en  = 1'b0;
  endtask

  task automatic wait_idle(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (!bus.busy) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    bus.pc_clk = 0; bus.pc = 0; bus.load_clk = 0; bus.load_en = 0; bus.l_addr = 0;
    bus.store_clk = 0; bus.store_en = 0; bus.s_addr = 0; bus.s_data = 0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_tests++;
    if ({bus.mem_req, bus.mem_we, bus.busy, bus.err_overrun, bus.err_timeout} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_flags got %b exp 00000",
               {bus.mem_req, bus.mem_we, bus.busy, bus.err_overrun, bus.err_timeout});
    end
    n_tests++;
    if ({bus.mem_addr, bus.mem_wdata} !== 64'h0) begin
      n_fail++;
      $display("FAIL reset_mem_bus got %h/%h exp 0/0", bus.mem_addr, bus.mem_wdata);
    end
    n_tests++;
    if ({bus.read_inst, bus.l_data} !== 64'h0) begin
      n_fail++;
      $display("FAIL reset_data got %h/%h exp 0/0", bus.read_inst, bus.l_data);
    end
    rst = 1'b0;
    repeat (2) @(negedge clk);
    n_tests++;
    if ({bus.mem_req, bus.busy} !== 2'b00) begin
      n_fail++;
      $display("FAIL post_reset_idle got %b exp 00", {bus.mem_req, bus.busy});
    end
  endtask

  task automatic test_fetch();
    mem_arr[32'h40] = 32'h2402_0005;
    lat = 0;
    strobe(1, 32'h40, 0, 0, 0, 0, 0, 0, 0);
    n_tests++;
    if ({bus.mem_req, bus.busy} !== 2'b01) begin
      n_fail++;
      $display("FAIL fetch_capture got req/busy %b exp 01", {bus.mem_req, bus.busy});
    end
    @(negedge clk);
    n_tests++;
    if ({bus.mem_req, bus.mem_we, bus.mem_addr} !== {2'b10, 32'h40}) begin
      n_fail++;
      $display("FAIL fetch_issue got req=%b we=%b addr=%h exp 1 0 00000040",
               bus.mem_req, bus.mem_we, bus.mem_addr);
    end
    @(negedge clk);
    n_tests++;
    if (bus.read_inst !== 32'h2402_0005) begin
      n_fail++;
      $display("FAIL fetch_data got %h exp 24020005", bus.read_inst);
    end
    n_tests++;
    if ({bus.busy, bus.mem_req} !== 2'b00) begin
      n_fail++;
      $display("FAIL fetch_busy_drop got %b exp 00", {bus.busy, bus.mem_req});
    end
  endtask

  task automatic test_store_load();
    bit ok;
    lat = 3;
    log_q.delete();
    strobe(0, 0, 1, 1, 32'h100, 1, 1, 32'h100, 32'hA5A5_A5A5);
    wait_idle(ok);
    n_tests++;
    if (!ok) begin
      n_fail++;
      $display("FAIL sl_idle got busy exp idle");
    end
    n_tests++;
    if (log_q.size() != 2 || log_q[0].we !== 1'b1 || log_q[0].addr !== 32'h100 ||
        log_q[0].wdata !== 32'hA5A5_A5A5 || log_q[1].we !== 1'b0 || log_q[1].addr !== 32'h100) begin
      n_fail++;
      $display("FAIL sl_order got %0d txns exp write then read at 00000100", log_q.size());
    end
    n_tests++;
    if (bus.l_data !== 32'hA5A5_A5A5) begin
      n_fail++;
      $display("FAIL sl_ldata got %h exp a5a5a5a5", bus.l_data);
    end
  endtask

  task automatic test_ignored_enable();
    bit seen;
    seen = 1'b0;
    lat = 0;
    strobe(0, 0, 1, 0, 32'h104, 1, 0, 32'h108, 32'h1234_5678);
    for (int i = 0; i < 5; i++) begin
      if (bus.mem_req || bus.busy) seen = 1'b1;
      @(negedge clk);
    end
    n_tests++;
    if (seen !== 1'b0) begin
      n_fail++;
      $display("FAIL ignored_en got activity 1 exp 0");
    end
    n_tests++;
    if (bus.l_data !== 32'hA5A5_A5A5) begin
      n_fail++;
      $display("FAIL ignored_ldata got %h exp a5a5a5a5", bus.l_data);
    end
  endtask

  task automatic test_overrun();
    bit ok;
    ack_en = 1'b0;
    lat = 0;
    log_q.delete();
    strobe(1, 32'h80, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    n_tests++;
    if ({bus.mem_req, bus.err_overrun} !== 2'b10) begin
      n_fail++;
      $display("FAIL ovr_pre got req/ovr %b exp 10", {bus.mem_req, bus.err_overrun});
    end
    strobe(1, 32'h84, 0, 0, 0, 0, 0, 0, 0);
    n_tests++;
    if (bus.err_overrun !== 1'b1 || bus.mem_addr !== 32'h80) begin
      n_fail++;
      $display("FAIL ovr_flag got ovr=%b addr=%h exp 1 00000080", bus.err_overrun, bus.mem_addr);
    end
    ack_en = 1'b1;
    wait_idle(ok);
    repeat (4) @(negedge clk);
    n_tests++;
    if (!ok || log_q.size() != 1 || log_q[0].addr !== 32'h80) begin
      n_fail++;
      $display("FAIL ovr_single got %0d fetches exp 1 at 00000080", log_q.size());
    end
    n_tests++;
    if (bus.read_inst !== dflt(32'h80) || bus.err_overrun !== 1'b1) begin
      n_fail++;
      $display("FAIL ovr_data got %h ovr=%b exp %h ovr=1", bus.read_inst, bus.err_overrun, dflt(32'h80));
    end
  endtask

  task automatic test_idle_ack();
    bit seen;
    seen = 1'b0;
    force_ack = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (bus.mem_req || bus.busy) seen = 1'b1;
    end
    force_ack = 1'b0;
    @(negedge clk);
    n_tests++;
    if (seen !== 1'b0 || bus.read_inst !== dflt(32'h80) || bus.l_data !== 32'hA5A5_A5A5) begin
      n_fail++;
      $display("FAIL idle_ack got act=%b inst=%h ld=%h exp 0 %h a5a5a5a5",
               seen, bus.read_inst, bus.l_data, dflt(32'h80));
    end
  endtask

  task automatic test_reset_mid();
    ack_en = 1'b0;
    strobe(1, 32'h200, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    n_tests++;
    if (bus.mem_req !== 1'b1) begin
      n_fail++;
      $display("FAIL rmid_req got %b exp 1", bus.mem_req);
    end
    rst = 1'b1;
    @(negedge clk);
    n_tests++;
    if ({bus.mem_req, bus.busy, bus.err_overrun, bus.read_inst} !== 35'h0) begin
      n_fail++;
      $display("FAIL rmid_reset got req=%b busy=%b ovr=%b inst=%h exp 0 0 0 0",
               bus.mem_req, bus.busy, bus.err_overrun, bus.read_inst);
    end
    rst = 1'b0;
    force_ack = 1'b1;
    repeat (2) @(negedge clk);
    force_ack = 1'b0;
    @(negedge clk);
    n_tests++;
    if ({bus.mem_req, bus.busy, bus.read_inst} !== 34'h0) begin
      n_fail++;
      $display("FAIL rmid_late_ack got req=%b busy=%b inst=%h exp 0 0 0",
               bus.mem_req, bus.busy, bus.read_inst);
    end
    ack_en = 1'b1;
  endtask

  task automatic test_random();
    logic [31:0] exp_inst;
    logic [31:0] exp_ldata;
    exp_inst  = '0;
    exp_ldata = '0;
    for (int it = 0; it < 40; it++) begin
      bit f, l, len, s, sen, xf, ok, good;
      logic [31:0] pcv, la, sa, sd, a;
      txn_t exp_q[$];
      txn_t t;
      exp_q.delete();
      f   = 1'($urandom_range(0, 1));
      l   = 1'($urandom_range(0, 1));
      len = 1'($urandom_range(0, 1));
      s   = 1'($urandom_range(0, 1));
      sen = 1'($urandom_range(0, 1));
      xf  = !f && ($urandom_range(0, 1) == 1);
      pcv = 32'h1000 + 32'($urandom_range(0, 63));
      la  = 32'h1000 + 32'($urandom_range(0, 63));
      sa  = 32'h1000 + 32'($urandom_range(0, 63));
      sd  = $urandom;
      lat = $urandom_range(0, 3);
      if (s && sen) begin
        a = sa & ~32'h3;
        t.we = 1'b1; t.addr = a; t.wdata = sd;
        exp_q.push_back(t);
        ref_mem[a] = sd;
      end
      if (l && len) begin
        a = la & ~32'h3;
        t.we = 1'b0; t.addr = a; t.wdata = '0;
        exp_q.push_back(t);
        exp_ldata = ref_rd(a);
      end
      if (f || xf) begin
        a = pcv & ~32'h3;
        t.we = 1'b0; t.addr = a; t.wdata = '0;
        exp_q.push_back(t);
        exp_inst = ref_rd(a);
      end
      log_q.delete();
      strobe(f, pcv, l, len, la, s, sen, sa, sd);
      if (xf) strobe(1, pcv, 0, 0, 0, 0, 0, 0, 0);
      wait_idle(ok);
      good = ok && (log_q.size() == exp_q.size());
      if (good) begin
        foreach (exp_q[k]) begin
          if (log_q[k].we !== exp_q[k].we || log_q[k].addr !== exp_q[k].addr ||
              (exp_q[k].we && log_q[k].wdata !== exp_q[k].wdata)) good = 1'b0;
        end
      end
      n_tests++;
      if (!good) begin
        n_fail++;
        $display("FAIL rand_txn iter %0d got %0d txns (idle=%b) exp %0d in store/load/fetch order",
                 it, log_q.size(), ok, exp_q.size());
      end
      n_tests++;
      if (bus.l_data !== exp_ldata || bus.read_inst !== exp_inst) begin
        n_fail++;
        $display("FAIL rand_data iter %0d got ld=%h inst=%h exp ld=%h inst=%h",
                 it, bus.l_data, bus.read_inst, exp_ldata, exp_inst);
      end
    end
    n_tests++;
    if (bus.err_overrun !== 1'b0) begin
      n_fail++;
      $display("FAIL rand_no_overrun got %b exp 0", bus.err_overrun);
    end
  endtask

  task automatic test_timeout();
`ifdef MEM_CTRL_TIMEOUT_EN
    int req_cycles;
    req_cycles = 0;
    ack_en = 1'b0;
    strobe(0, 0, 1, 1, 32'h300, 0, 0, 0, 0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bus.mem_req) req_cycles++;
    end
    n_tests++;
    if (req_cycles != 4) begin
      n_fail++;
      $display("FAIL tmo_req_cycles got %0d exp 4", req_cycles);
    end
    n_tests++;
    if (bus.l_data !== 32'hFFFF_FFFF || bus.err_timeout !== 1'b1 || bus.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL tmo_result got ld=%h tmo=%b busy=%b exp ffffffff 1 0",
               bus.l_data, bus.err_timeout, bus.busy);
    end
    ack_en = 1'b1;
`else
    bit ok;
    ack_en = 1'b0;
    strobe(0, 0, 1, 1, 32'h300, 0, 0, 0, 0);
    repeat (300) @(negedge clk);
    n_tests++;
    if ({bus.mem_req, bus.busy, bus.err_timeout} !== 3'b110) begin
      n_fail++;
      $display("FAIL no_tmo_wait got req/busy/tmo %b exp 110",
               {bus.mem_req, bus.busy, bus.err_timeout});
    end
    ack_en = 1'b1;
    wait_idle(ok);
    n_tests++;
    if (!ok || bus.l_data !== dflt(32'h300)) begin
      n_fail++;
      $display("FAIL no_tmo_done got ld=%h idle=%b exp %h 1", bus.l_data, ok, dflt(32'h300));
    end
`endif
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_fetch();
    test_store_load();
    test_ignored_enable();
    test_overrun();
    test_idle_ack();
    test_reset_mid();
    test_random();
    test_timeout();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
